// File: rtl/adder_rr_ctrl.sv
// Round-robin front end for one shared multi-cycle adder: it arbitrates the requesters,
// registers the winner's operands, waits out the adder latency and returns the sum with an ack pulse.
module adder_rr_ctrl #(
    parameter int N_REQ   = 4,
    parameter int WIDTH   = 4,
    parameter int ADD_LAT = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*WIDTH-1:0]   a_bus,
    input  logic [N_REQ*WIDTH-1:0]   b_bus,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         ack,
    output logic [WIDTH:0]           result,
    output logic [$clog2(N_REQ)-1:0] result_id,
    output logic                     busy,
    output logic [WIDTH-1:0]         add_a,
    output logic [WIDTH-1:0]         add_b,
    input  logic [WIDTH:0]           add_sum
);
    localparam int IDW = $clog2(N_REQ);
    localparam int CW  = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [WIDTH-1:0]   add_a_q, add_a_d;
    logic [WIDTH-1:0]   add_b_q, add_b_d;
    logic [WIDTH:0]     result_q, result_d;
    logic [IDW-1:0]     result_id_q, result_id_d;
    logic               busy_q, busy_d;

    logic [WIDTH-1:0]   a_arr [N_REQ];
    logic [WIDTH-1:0]   b_arr [N_REQ];
    logic               win_found;
    logic [IDW-1:0]     win_idx;
    logic [IDW-1:0]     cand;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slice
            assign a_arr[gi] = a_bus[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = b_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] idx);
        logic [N_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Scan from the farthest offset down to ptr+1 so the nearest set bit after ptr wins.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDW'((int'(ptr_q) + k) % N_REQ);
            if (req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        ack_d       = '0;
        add_a_d     = add_a_q;
        add_b_d     = add_b_q;
        result_d    = result_q;
        result_id_d = result_id_q;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    add_a_d     = a_arr[win_idx];
                    add_b_d     = b_arr[win_idx];
                    gnt_d       = onehot(win_idx);
                    ptr_d       = win_idx;
                    result_id_d = win_idx;
                    cnt_d       = '0;
                    state_d     = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CW'(ADD_LAT - 1)) begin
                    result_d = add_sum;
                    ack_d    = onehot(result_id_q);
                    gnt_d    = '0;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Registered from the next state so busy lines up with the state register.
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= IDW'(N_REQ - 1);
            gnt_q       <= '0;
            ack_q       <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            result_q    <= '0;
            result_id_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            ack_q       <= ack_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            result_q    <= result_d;
            result_id_q <= result_id_d;
            busy_q      <= busy_d;
        end
    end

    assign gnt       = gnt_q;
    assign ack       = ack_q;
    assign result    = result_q;
    assign result_id = result_id_q;
    assign busy      = busy_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;

endmodule

// File: tb/tb_adder_rr_ctrl.sv
// Directed bench for adder_rr_ctrl: vector table of single operations plus hand-written
// sequences for reset abort, round-robin fairness, operand hold and requests arriving in DONE.
module tb_adder_rr_ctrl;
    localparam int N_REQ   = 4;
    localparam int WIDTH   = 4;
    localparam int ADD_LAT = 2;
    localparam int IDW     = 2;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] a_bus;
    logic [N_REQ*WIDTH-1:0] b_bus;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       ack;
    logic [WIDTH:0]         result;
    logic [IDW-1:0]         result_id;
    logic                   busy;
    logic [WIDTH-1:0]       add_a;
    logic [WIDTH-1:0]       add_b;
    logic [WIDTH:0]         add_sum;
    logic [WIDTH:0]         sum_d1;

    int n_checks;
    int n_errors;

    adder_rr_ctrl #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
        .clk(clk), .rst(rst), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .ack(ack), .result(result), .result_id(result_id), .busy(busy),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Adder model: the sum of new inputs only appears one edge after they change,
    // so a capture before the full latency picks up a stale value.
    always @(posedge clk) sum_d1 <= {1'b0, add_a} + {1'b0, add_b};
    assign add_sum = sum_d1;

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        int          id;
        logic [4:0]  sum;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] oh(input int i);
        logic [3:0] v;
        v = 4'b0001 << i;
        return v;
    endfunction

    initial begin
        logic [3:0] exp_a;
        logic [3:0] exp_b;
        int n_ack;
        int last_cyc;
        n_checks = 0;
        n_errors = 0;
        sum_d1 = '0;
        rst = 1'b1;
        req = '0;
        a_bus = '0;
        b_bus = '0;

        // ptr starts at 3; each row's winner depends on the previous row's winner.
        vecs[0] = '{4'b0100, 16'h1523, 16'h2641, 2, 5'd11};
        vecs[1] = '{4'b0001, 16'h123F, 16'h456F, 0, 5'b11110};
        vecs[2] = '{4'b1010, 16'hC07A, 16'h4080, 1, 5'd15};
        vecs[3] = '{4'b1011, 16'h9123, 16'h9456, 3, 5'd18};
        vecs[4] = '{4'b0011, 16'h0021, 16'h0030, 0, 5'd1};
        vecs[5] = '{4'b0001, 16'h0008, 16'h0008, 0, 5'd16};
        vecs[6] = '{4'b1000, 16'hF000, 16'h1000, 3, 5'd16};

        #12;
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_ack", 32'(ack), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_result", 32'(result), 32'h0);
        step();
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++) begin
            req = vecs[i].req;
            a_bus = vecs[i].a;
            b_bus = vecs[i].b;
            exp_a = vecs[i].a[vecs[i].id*4 +: 4];
            exp_b = vecs[i].b[vecs[i].id*4 +: 4];
            step();
            chk("vec_gnt", 32'(gnt), 32'(oh(vecs[i].id)));
            chk("vec_add_a", 32'(add_a), 32'(exp_a));
            chk("vec_add_b", 32'(add_b), 32'(exp_b));
            chk("vec_busy", 32'(busy), 32'h1);
            step();
            chk("vec_ack_early", 32'(ack), 32'h0);
            step();
            chk("vec_ack", 32'(ack), 32'(oh(vecs[i].id)));
            chk("vec_result", 32'(result), 32'(vecs[i].sum));
            chk("vec_result_id", 32'(result_id), 32'(vecs[i].id));
            chk("vec_gnt_clr", 32'(gnt), 32'h0);
            req = '0;
            step();
            chk("vec_ack_drop", 32'(ack), 32'h0);
            chk("vec_busy_drop", 32'(busy), 32'h0);
            $display("vec %0d: req=%b id=%0d result=%0d", i, vecs[i].req, result_id, result);
        end

        // Reset in the middle of WAIT discards the operation.
        req = 4'b0010;
        a_bus = 16'h0030;
        b_bus = 16'h0040;
        step();
        chk("rst_op_gnt", 32'(gnt), 32'h2);
        req = '0;
        step();
        #2 rst = 1'b1;
        #1;
        chk("rst_async_gnt", 32'(gnt), 32'h0);
        chk("rst_async_busy", 32'(busy), 32'h0);
        chk("rst_async_result", 32'(result), 32'h0);
        chk("rst_async_add_a", 32'(add_a), 32'h0);
        chk("rst_async_add_b", 32'(add_b), 32'h0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_no_ack", 32'(ack), 32'h0);
        end
        $display("reset abort: gnt=%b ack=%b busy=%0d", gnt, ack, busy);
        rst = 1'b0;

        // Continuous requests from everyone: grants rotate 0,1,2,3,0 with acks 4 cycles apart.
        req = 4'b1111;
        a_bus = 16'h4321;
        b_bus = 16'h1111;
        n_ack = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n_ack < 5; cyc++) begin
            step();
            if (cyc == 0) chk("rst_prio_gnt", 32'(gnt), 32'h1);
            if (ack != 4'b0000) begin
                chk("rr_ack", 32'(ack), 32'(oh(n_ack % 4)));
                chk("rr_result", 32'(result), 32'((n_ack % 4) + 2));
                if (n_ack > 0) chk("rr_spacing", 32'(cyc - last_cyc), 32'd4);
                $display("rr ack %0d: id=%0d cycle=%0d result=%0d", n_ack, result_id, cyc, result);
                last_cyc = cyc;
                n_ack++;
            end
        end
        chk("rr_ack_count", 32'(n_ack), 32'd5);
        req = '0;
        step();

        // Operand bus and req change after acceptance must not disturb the operation.
        req = 4'b1000;
        a_bus = 16'h9555;
        b_bus = 16'h2777;
        step();
        chk("hold_add_a", 32'(add_a), 32'h9);
        a_bus = 16'h0555;
        req = '0;
        step();
        chk("hold_add_a_wait", 32'(add_a), 32'h9);
        step();
        chk("hold_ack", 32'(ack), 32'h8);
        chk("hold_result", 32'(result), 32'b01011);
        $display("hold: id=%0d result=%0d", result_id, result);
        step();

        // req[1] rises during DONE of requester 0's operation.
        req = 4'b0001;
        a_bus = 16'h0003;
        b_bus = 16'h0004;
        step();
        step();
        step();
        chk("done_ack0", 32'(ack), 32'h1);
        chk("done_result0", 32'(result), 32'd7);
        req = 4'b0010;
        a_bus = 16'h0050;
        b_bus = 16'h0060;
        step();
        chk("done_no_accept", 32'(gnt), 32'h0);
        chk("done_idle_busy", 32'(busy), 32'h0);
        step();
        chk("done_next_gnt", 32'(gnt), 32'h2);
        chk("done_next_busy", 32'(busy), 32'h1);
        req = '0;
        step();
        step();
        chk("done_ack1", 32'(ack), 32'h2);
        chk("done_result1", 32'(result), 32'd11);
        chk("done_result_id1", 32'(result_id), 32'd1);
        $display("done-request: id=%0d result=%0d", result_id, result);
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/adder_rr_ctrl.md
# adder_rr_ctrl

Round-robin controller that shares one WIDTH-bit adder (WIDTH+1-bit sum, fixed propagation latency) between N_REQ requesters. It sits between the requesters and the adder instance: it arbitrates, registers the winner's operands onto the adder inputs, and waits out the adder delay. It then captures the sum and returns it to the winner with a one-cycle acknowledge.

## Interface
Parameters:
- N_REQ, 4, number of requesters (≥2)
- WIDTH, 4, operand width
- ADD_LAT, 2, clock cycles the adder output needs to settle after its inputs change (≥1)
- IDW, $clog2(N_REQ), requester-index width (derived, localparam)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- req  in  N_REQ  per-requester request level
- a_bus  in  N_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- b_bus  in  N_REQ*WIDTH  operand B, same packing
- gnt  out  N_REQ  one-hot grant, held for the whole operation
- ack  out  N_REQ  one-hot, one-cycle result-valid pulse to the winner
- result  out  WIDTH+1  captured sum, carry in MSB
- result_id  out  IDW  index of the requester that owns result
- busy  out  1  high whenever the state is not IDLE
- add_a  out  WIDTH  registered operand A to the adder
- add_b  out  WIDTH  registered operand B to the adder
- add_sum  in  WIDTH+1  adder output

## Operation
- States: IDLE, WAIT, DONE.
- IDLE: if req is nonzero, pick the winner by round-robin. The search starts at ptr+1 and wraps modulo N_REQ; the first set bit wins. On that edge:
  - add_a/add_b are loaded from the winner's slices.
  - gnt = onehot(winner); ptr = winner; result_id = winner.
  - cnt = 0; go to WAIT.
- If req is zero, stay in IDLE with all outputs held.
- WAIT: add_a/add_b are held stable.
  - If cnt == ADD_LAT-1: result = add_sum, ack = onehot(winner), gnt = 0, go to DONE.
  - Otherwise cnt increments.
- DONE: ack is high for exactly this cycle. req is ignored in this cycle. Next edge: ack = 0, go to IDLE.
- Operands are sampled only at the acceptance edge. Later changes on a_bus/b_bus do not affect the operation in flight.
- If req drops during WAIT, the operation still completes and ack is still issued. Requesters must drop req during their ack cycle, or a new request is seen in IDLE.
- Requesters that arrive while busy wait. Only one operation is ever in flight.
- result is passed through from add_sum unchanged, full WIDTH+1 bits. result and result_id hold until the next capture.
- ptr resets to N_REQ-1, so requester 0 has first priority after reset.
- Reset (async, any state): state = IDLE, cnt = 0, ptr = N_REQ-1. gnt, ack, add_a, add_b, result, result_id and busy are all 0. An operation in flight is discarded and no ack is produced.

## Timing
- Acceptance edge E0 (IDLE with req nonzero). From E0: gnt, add_a, add_b and busy are valid.
- The adder sees stable inputs for ADD_LAT edges, E1..E_ADD_LAT.
- At E_ADD_LAT: result and ack are registered, and ack is high in the following cycle.
- At E_ADD_LAT+1: ack drops and the state returns to IDLE.
- The earliest next acceptance is E_ADD_LAT+2. Throughput is one operation per ADD_LAT+2 cycles.
- With ADD_LAT=2: ack is high in the 3rd cycle after acceptance, and back-to-back operations are 4 cycles apart.
- busy is high from after E0 through the DONE cycle inclusive.
- All outputs are registered; there are no combinational paths from req/a_bus/b_bus to any output.

## Test plan
- Reset mid-operation: accept req[1] with a=3, b=4, and assert rst during WAIT. Required: all outputs 0 immediately (asynchronous), no ack ever for req[1]. After release, requester 0 is first priority.
- Single request, ADD_LAT=2: req[2]=1, a=5, b=6. Required: gnt=4'b0100 after E0; add_a=5, add_b=6; after E2, result=5'b01011, result_id=2, ack=4'b0100 for one cycle; busy low after E3.
- Carry out: req[0] with a=15, b=15. Required: result=5'b11110, ack[0] pulses once.
- Round-robin fairness: hold req=4'b1111 continuously (each requester re-requesting after its ack). Required: grant order 0,1,2,3,0,… with acks spaced 4 cycles apart.
- Operand/req changes after acceptance: accept req[3] with a=9, b=2, then change a_bus slice 3 to 0 and drop req[3] during WAIT. Required: result=5'b01011, ack[3] still pulses.
- Request in DONE: req[1] rises in the DONE cycle of requester 0's operation. Required: req[1] is not accepted until the following IDLE edge; gnt=4'b0010 one cycle after DONE.
